// File: rtl/coproc_pkg.sv
// Shared types and constants for the coprocessor register bank.
package coproc_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 4;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cmd_state_t;

  // Index width for n registers: ceil(log2(n)), never below one bit.
  function automatic int addr_w(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/coproc_cmd_ctrl.sv
// Command handshake: a commit write raises cmd_valid until the consumer acks;
// a commit over an unacknowledged command sets the sticky overrun flag.
module coproc_cmd_ctrl
  import coproc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic commit,
  input  logic cmd_ack,
  output logic cmd_valid,
  output logic cmd_overrun
);

  cmd_state_t state_r;

  // Command state machine with registered outputs; a commit always wins over an ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cmd_valid   <= 1'b0;
      cmd_overrun <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (commit) begin
            state_r   <= PENDING;
            cmd_valid <= 1'b1;
          end else begin
            state_r   <= IDLE;
            cmd_valid <= 1'b0;
          end
        end
        PENDING: begin
          if (commit) begin
            state_r   <= PENDING;
            cmd_valid <= 1'b1;
            if (!cmd_ack) begin
              cmd_overrun <= 1'b1;
            end else begin
              cmd_overrun <= cmd_overrun;
            end
          end else if (cmd_ack) begin
            state_r   <= IDLE;
            cmd_valid <= 1'b0;
          end else begin
            state_r   <= PENDING;
            cmd_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/coproc_reg_bank.sv
// Coprocessor register bank with per-register fresh tracking and a commit command.
// Define COPROC_REG_BANK_BYPASS_EN to forward same-cycle write data to a read of that register.
module coproc_reg_bank
  import coproc_pkg::*;
#(
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int NUM_REGS   = DEF_NUM_REGS,
  parameter  int COMMIT_IDX = 2,
  localparam int ADDR_W     = addr_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_fresh,
  output logic              rd_valid,
  output logic              cmd_valid,
  input  logic              cmd_ack,
  output logic              cmd_overrun
);

  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] fresh_r;
  logic [NUM_REGS-1:0] fresh_nxt_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic                rd_fresh_s;
  logic                wr_hit_s;
  logic                rd_hit_s;
  logic                same_s;
  logic                commit_s;

  assign wr_hit_s = wr_en && (32'(wr_addr) < 32'(NUM_REGS));
  assign rd_hit_s = rd_en && (32'(rd_addr) < 32'(NUM_REGS));
  assign same_s   = wr_hit_s && rd_hit_s && (wr_addr == rd_addr);
  assign commit_s = wr_hit_s && (wr_addr == ADDR_W'(COMMIT_IDX));

  // Read mux: out-of-range reads return zero; bypass forwards the incoming write.
  always_comb begin
    rd_word_s  = '0;
    rd_fresh_s = 1'b0;
    if (rd_hit_s) begin
`ifdef COPROC_REG_BANK_BYPASS_EN
      if (same_s) begin
        rd_word_s  = wr_data;
        rd_fresh_s = 1'b1;
      end else begin
        rd_word_s  = regs_r[rd_addr];
        rd_fresh_s = fresh_r[rd_addr];
      end
`else
      rd_word_s  = regs_r[rd_addr];
      rd_fresh_s = fresh_r[rd_addr];
`endif
    end else begin
      rd_word_s  = '0;
      rd_fresh_s = 1'b0;
    end
  end

  // Fresh bits: without bypass a write beats the read clear; with bypass the read consumes it.
  always_comb begin
    fresh_nxt_s = fresh_r;
    for (int i = 0; i < NUM_REGS; i++) begin
`ifdef COPROC_REG_BANK_BYPASS_EN
      fresh_nxt_s[i] = (rd_hit_s && (rd_addr == ADDR_W'(i))) ? 1'b0 :
                       ((wr_hit_s && (wr_addr == ADDR_W'(i))) | fresh_r[i]);
`else
      fresh_nxt_s[i] = (wr_hit_s && (wr_addr == ADDR_W'(i))) |
                       (fresh_r[i] & ~(rd_hit_s && (rd_addr == ADDR_W'(i))));
`endif
    end
  end

  // Storage array, fresh bits and the registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
      fresh_r  <= '0;
      rd_data  <= '0;
      rd_fresh <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_hit_s) begin
        regs_r[wr_addr] <= wr_data;
      end else begin
        regs_r[wr_addr] <= regs_r[wr_addr];
      end
      fresh_r  <= fresh_nxt_s;
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data  <= rd_word_s;
        rd_fresh <= rd_fresh_s;
      end else begin
        rd_data  <= rd_data;
        rd_fresh <= rd_fresh;
      end
    end
  end

  coproc_cmd_ctrl u_cmd_ctrl (
    .clk         (clk),
    .reset       (reset),
    .commit      (commit_s),
    .cmd_ack     (cmd_ack),
    .cmd_valid   (cmd_valid),
    .cmd_overrun (cmd_overrun)
  );

endmodule

// File: tb/tb_coproc_reg_bank.sv
// Scoreboard bench for coproc_reg_bank: reads push expectations, rd_valid pops them.
// NREGS is 6 so the 3-bit address port can express out-of-range indices.
module tb_coproc_reg_bank;

  localparam int DW    = 32;
  localparam int NREGS = 6;
  localparam int CIDX  = 2;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_fresh;
  logic          rd_valid;
  logic          cmd_valid;
  logic          cmd_ack = 1'b0;
  logic          cmd_overrun;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0]    m_reg [NREGS];
  logic [NREGS-1:0] m_fresh = '0;
  logic             m_cmd = 1'b0;
  logic             m_ovr = 1'b0;
  logic [DW-1:0]    m_rd_data = '0;
  logic             m_rd_fresh = 1'b0;
  logic [DW:0]      exp_q [$];

  coproc_reg_bank #(.DATA_W(DW), .NUM_REGS(NREGS), .COMMIT_IDX(CIDX)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_fresh(rd_fresh),
    .rd_valid(rd_valid), .cmd_valid(cmd_valid), .cmd_ack(cmd_ack), .cmd_overrun(cmd_overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
    m_fresh = '0;
    m_cmd = 1'b0;
    m_ovr = 1'b0;
    m_rd_data = '0;
    m_rd_fresh = 1'b0;
    exp_q.delete();
  endtask

  // One clock: drive at posedge+1, update the model, check after the next posedge.
  task automatic drive(input bit we, input int wa, input logic [DW-1:0] wd,
                       input bit re, input int ra, input bit ack);
    logic [DW:0] e;
    bit commit;
    wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    rd_en = re; rd_addr = AW'(ra); cmd_ack = ack;
    if (re) begin
      if (ra < NREGS) begin
        e = {m_fresh[ra], m_reg[ra]};
`ifdef COPROC_REG_BANK_BYPASS_EN
        if (we && wa == ra) e = {1'b1, wd};
`endif
      end else begin
        e = '0;
      end
      exp_q.push_back(e);
    end
`ifdef COPROC_REG_BANK_BYPASS_EN
    if (we && wa < NREGS) m_fresh[wa] = 1'b1;
    if (re && ra < NREGS) m_fresh[ra] = 1'b0;
`else
    if (re && ra < NREGS) m_fresh[ra] = 1'b0;
    if (we && wa < NREGS) m_fresh[wa] = 1'b1;
`endif
    if (we && wa < NREGS) m_reg[wa] = wd;
    commit = we && (wa == CIDX);
    if (m_cmd) begin
      if (commit && !ack) m_ovr = 1'b1;
      m_cmd = commit || !ack;
    end else begin
      m_cmd = commit;
    end
    @(posedge clk);
    #1;
    check_eq("rd_valid", {63'd0, rd_valid}, {63'd0, re});
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("rd_valid_unexpected", {63'd0, rd_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        m_rd_data = e[DW-1:0];
        m_rd_fresh = e[DW];
      end
    end
    check_eq("rd_data", {32'd0, rd_data}, {32'd0, m_rd_data});
    check_eq("rd_fresh", {63'd0, rd_fresh}, {63'd0, m_rd_fresh});
    check_eq("cmd_valid", {63'd0, cmd_valid}, {63'd0, m_cmd});
    check_eq("cmd_overrun", {63'd0, cmd_overrun}, {63'd0, m_ovr});
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rd_data"}, {32'd0, rd_data}, 64'd0);
    check_eq({tag, "_rd_fresh"}, {63'd0, rd_fresh}, 64'd0);
    check_eq({tag, "_rd_valid"}, {63'd0, rd_valid}, 64'd0);
    check_eq({tag, "_cmd_valid"}, {63'd0, cmd_valid}, 64'd0);
    check_eq({tag, "_cmd_overrun"}, {63'd0, cmd_overrun}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    #12;
    check_all_zero("reset");
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic write/read and fresh consumption.
    drive(1, 1, 32'hDEADBEEF, 0, 0, 0);
    drive(0, 0, 32'h0, 1, 1, 0);
    drive(0, 0, 32'h0, 1, 1, 0);
    drive(0, 0, 32'h0, 0, 0, 0);
    drive(1, 0, 32'h11, 0, 0, 0);
    drive(1, 3, 32'hA5A5, 0, 0, 0);

    // Out-of-range reads and ignored writes.
    drive(0, 0, 32'h0, 1, NREGS, 0);
    drive(1, NREGS, 32'hFFFFFFFF, 1, 7, 0);
    drive(1, 7, 32'hCAFEF00D, 0, 0, 0);
    for (int i = 0; i < NREGS; i++) drive(0, 0, 32'h0, 1, i, 0);

    // Commit held for three cycles then acked; ack while idle is ignored.
    drive(1, CIDX, 32'h5, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 32'h0, 0, 0, 0);
    drive(0, 0, 32'h0, 0, 0, 1);
    drive(0, 0, 32'h0, 0, 0, 1);

    // Overrun, then commit together with ack keeps the command pending.
    drive(1, CIDX, 32'h6, 0, 0, 0);
    drive(1, CIDX, 32'h7, 0, 0, 0);
    drive(1, CIDX, 32'h8, 0, 0, 1);
    drive(0, 0, 32'h0, 0, 0, 1);
    drive(0, 0, 32'h0, 0, 0, 0);

    // Same-cycle write and read of one register, then a different-address pair.
    drive(1, 0, 32'h11, 0, 0, 0);
    drive(0, 0, 32'h0, 1, 0, 0);
    drive(1, 0, 32'h77, 1, 0, 0);
    drive(0, 0, 32'h0, 1, 0, 0);
    drive(1, 4, 32'h1234, 1, 3, 0);
    drive(0, 0, 32'h0, 1, 4, 0);

    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a pending command.
    drive(1, 0, 32'h11, 0, 0, 0);
    drive(1, CIDX, 32'h9, 1, 0, 0);
    #2;
    wr_en = 1'b0; rd_en = 1'b0; cmd_ack = 1'b0;
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    model_clear();
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 0, 32'h0, 1, 0, 0);
    drive(0, 0, 32'h0, 0, 0, 0);
    drive(0, 0, 32'h0, 1, CIDX, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
